// File: rtl/multiplicador_secuencial_if.sv
// Handshake and data bundle of the sequential multiplier.
// The requester uses the master view; the multiplier uses the slave view.
interface multiplicador_secuencial_if #(
  parameter int N = 24
);
  logic           iniciar;
  logic [N-1:0]   Multiplicandos;
  logic [N-1:0]   Constantes;
  logic           ocupado;
  logic           listo;
  logic [2*N-1:0] Multip;
  logic [N-1:0]   Resultado;
  logic           Desborde;

  modport master (
    output iniciar, Multiplicandos, Constantes,
    input  ocupado, listo, Multip, Resultado, Desborde
  );

  modport slave (
    input  iniciar, Multiplicandos, Constantes,
    output ocupado, listo, Multip, Resultado, Desborde
  );
endinterface

// File: rtl/multiplicador_secuencial.sv
// Radix-2 shift-add multiplier with signed/unsigned operands and a rounded,
// saturated Q-format result; one multiplier bit is retired per clock.
module multiplicador_secuencial #(
  parameter int N      = 24,
  parameter int FRAC   = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  multiplicador_secuencial_if.slave bus
);
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int W   = 2*N + 1;
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic signed [W-1:0] RND  = (FRAC > 0) ? (W'(1) << RSH) : '0;
  localparam logic signed [W-1:0] SMAX = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {{(N+2){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [W-1:0] UMAX = {{(N+1){1'b0}}, {N{1'b1}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic             sign_q, sign_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             listo_q, listo_d;
  logic             desb_q, desb_d;
  logic [2*N-1:0]   multip_q, multip_d;
  logic [N-1:0]     res_q, res_d;

  logic [N-1:0]     a_mag, b_mag;
  logic             op_sign;
  logic [2*N-1:0]   multip_fin;
  logic signed [W-1:0] prod_ext, rnd_sum, rnd_shr;
  logic [N-1:0]     res_sat;
  logic             ovf;

  // Magnitudes are N-bit unsigned, so -2^(N-1) maps exactly to 2^(N-1).
  always_comb begin
    a_mag   = bus.Multiplicandos;
    b_mag   = bus.Constantes;
    op_sign = 1'b0;
    if (SIGNED) begin
      if (bus.Multiplicandos[N-1]) a_mag = -bus.Multiplicandos;
      if (bus.Constantes[N-1])     b_mag = -bus.Constantes;
      op_sign = bus.Multiplicandos[N-1] ^ bus.Constantes[N-1];
    end
  end

  // Rounding is done one bit wider than the product so the half-LSB add never wraps.
  always_comb begin
    multip_fin = sign_q ? -acc_q : acc_q;
    prod_ext   = SIGNED ? {multip_fin[2*N-1], multip_fin} : {1'b0, multip_fin};
    rnd_sum    = prod_ext + RND;
    rnd_shr    = rnd_sum >>> FRAC;
    res_sat    = rnd_shr[N-1:0];
    ovf        = 1'b0;
    if (SIGNED) begin
      if (rnd_shr > SMAX) begin
        res_sat = SMAX[N-1:0];
        ovf     = 1'b1;
      end else if (rnd_shr < SMIN) begin
        res_sat = SMIN[N-1:0];
        ovf     = 1'b1;
      end
    end else if (rnd_shr > UMAX) begin
      res_sat = UMAX[N-1:0];
      ovf     = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    listo_d  = 1'b0;
    desb_d   = desb_q;
    multip_d = multip_q;
    res_d    = res_q;
    case (state_q)
      IDLE: begin
        if (bus.iniciar) begin
          mcand_d  = {{N{1'b0}}, a_mag};
          mplier_d = b_mag;
          sign_d   = op_sign;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // The multiplicand shifts up while the multiplier shifts down, so bit i
        // of |B| always lines up with |A|<<i.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CW'(N-1)) state_d = FIN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      FIN: begin
        multip_d = multip_fin;
        res_d    = res_sat;
        desb_d   = ovf;
        listo_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      listo_q  <= 1'b0;
      desb_q   <= 1'b0;
      multip_q <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      listo_q  <= listo_d;
      desb_q   <= desb_d;
      multip_q <= multip_d;
      res_q    <= res_d;
    end
  end

  assign bus.ocupado   = (state_q == CALC) || (state_q == FIN);
  assign bus.listo     = listo_q;
  assign bus.Multip    = multip_q;
  assign bus.Resultado = res_q;
  assign bus.Desborde  = desb_q;
endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Self-checking bench for multiplicador_secuencial (N=24, FRAC=8, SIGNED=1):
// directed spec vectors, random operands against an integer model, protocol cases.
module tb_multiplicador_secuencial;
  localparam int N = 24;
  localparam int LAT = N + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  multiplicador_secuencial_if #(.N(N)) bus ();

  multiplicador_secuencial #(.N(N), .FRAC(8), .SIGNED(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact signed product in 64-bit integers, round half up, clamp.
  task automatic model(input logic [23:0] a, input logic [23:0] b,
                       output logic [47:0] mp, output logic [23:0] r, output logic d);
    longint sa, sb, p, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    q  = (p + 128) >>> 8;
    mp = p[47:0];
    d  = 1'b0;
    if (q > 64'sd8388607) begin
      r = 24'h7FFFFF; d = 1'b1;
    end else if (q < -64'sd8388608) begin
      r = 24'h800000; d = 1'b1;
    end else begin
      r = q[23:0];
    end
  endtask

  // Starts one operation from IDLE; returns edges from acceptance to listo
  // and the number of sampled cycles with ocupado high in between.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                        output int lat, output int ocnt);
    bus.iniciar = 1'b1;
    bus.Multiplicandos = a;
    bus.Constantes = b;
    @(posedge clk); #1;
    bus.iniciar = 1'b0;
    lat = 0;
    ocnt = 0;
    while (bus.listo !== 1'b1 && lat < 200) begin
      if (bus.ocupado === 1'b1) ocnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.iniciar = 1'b1;
    bus.Multiplicandos = 24'h000300;
    bus.Constantes = 24'h000280;
    repeat (2) @(posedge clk);
    #1;
    total += 5;
    if (bus.ocupado !== 1'b0) begin bad++; $display("FAIL reset_ocupado got=%b want=0", bus.ocupado); end
    if (bus.listo !== 1'b0) begin bad++; $display("FAIL reset_listo got=%b want=0", bus.listo); end
    if (bus.Multip !== 48'h0) begin bad++; $display("FAIL reset_multip got=%h want=0", bus.Multip); end
    if (bus.Resultado !== 24'h0) begin bad++; $display("FAIL reset_res got=%h want=0", bus.Resultado); end
    if (bus.Desborde !== 1'b0) begin bad++; $display("FAIL reset_desb got=%b want=0", bus.Desborde); end
    bus.iniciar = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.ocupado !== 1'b0) begin bad++; $display("FAIL reset_nostart got=%b want=0", bus.ocupado); end
    $display("reset: ocupado=%b listo=%b multip=%h res=%h", bus.ocupado, bus.listo, bus.Multip, bus.Resultado);
  endtask

  task automatic test_basic();
    int lat, ocnt;
    run_op(24'h000300, 24'h000280, lat, ocnt);
    total += 6;
    if (lat !== LAT) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
    if (ocnt !== LAT) begin bad++; $display("FAIL basic_ocupado_span got=%0d want=%0d", ocnt, LAT); end
    if (bus.ocupado !== 1'b0) begin bad++; $display("FAIL basic_ocupado_listo got=%b want=0", bus.ocupado); end
    if (bus.Multip !== 48'h000000078000) begin bad++; $display("FAIL basic_multip got=%h want=000000078000", bus.Multip); end
    if (bus.Resultado !== 24'h000780) begin bad++; $display("FAIL basic_res got=%h want=000780", bus.Resultado); end
    if (bus.Desborde !== 1'b0) begin bad++; $display("FAIL basic_desb got=%b want=0", bus.Desborde); end
    $display("basic: lat=%0d multip=%h res=%h desb=%b", lat, bus.Multip, bus.Resultado, bus.Desborde);
    @(posedge clk); #1;
    total += 2;
    if (bus.listo !== 1'b0) begin bad++; $display("FAIL basic_listo_pulse got=%b want=0", bus.listo); end
    if (bus.Resultado !== 24'h000780) begin bad++; $display("FAIL basic_hold got=%h want=000780", bus.Resultado); end
  endtask

  task automatic test_vectors();
    logic [23:0] va [8] = '{24'h000300, 24'hFFFE80, 24'h000001, 24'hFFFFFF,
                            24'hFFFFFF, 24'h7FFFFF, 24'h800000, 24'h800000};
    logic [23:0] vb [8] = '{24'h000280, 24'h000200, 24'h000080, 24'h000080,
                            24'h000180, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
    logic [47:0] vm [8] = '{48'h000000078000, 48'hFFFFFFFD0000, 48'h000000000080,
                            48'hFFFFFFFFFF80, 48'hFFFFFFFFFE80, 48'h3FFFFF000001,
                            48'h400000000000, 48'hC00000800000};
    logic [23:0] vr [8] = '{24'h000780, 24'hFFFD00, 24'h000001, 24'h000000,
                            24'hFFFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h800000};
    logic        vd [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int lat, ocnt;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], lat, ocnt);
      total += 4;
      if (lat !== LAT) begin bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, LAT); end
      if (bus.Multip !== vm[i]) begin bad++; $display("FAIL vec%0d_multip got=%h want=%h", i, bus.Multip, vm[i]); end
      if (bus.Resultado !== vr[i]) begin bad++; $display("FAIL vec%0d_res got=%h want=%h", i, bus.Resultado, vr[i]); end
      if (bus.Desborde !== vd[i]) begin bad++; $display("FAIL vec%0d_desb got=%b want=%b", i, bus.Desborde, vd[i]); end
      $display("vec%0d: a=%h b=%h multip=%h res=%h desb=%b", i, va[i], vb[i], bus.Multip, bus.Resultado, bus.Desborde);
    end
  endtask

  task automatic test_random();
    logic [23:0] a, b, er;
    logic [47:0] em;
    logic ed;
    int lat, ocnt;
    for (int i = 0; i < 24; i++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      if (i % 4 == 1) b = 24'($urandom_range(0, 1023));
      if (i % 4 == 2) a = {{12{a[23]}}, a[11:0]};
      model(a, b, em, er, ed);
      run_op(a, b, lat, ocnt);
      total += 4;
      if (lat !== LAT) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, LAT); end
      if (bus.Multip !== em) begin bad++; $display("FAIL rnd%0d_multip a=%h b=%h got=%h want=%h", i, a, b, bus.Multip, em); end
      if (bus.Resultado !== er) begin bad++; $display("FAIL rnd%0d_res a=%h b=%h got=%h want=%h", i, a, b, bus.Resultado, er); end
      if (bus.Desborde !== ed) begin bad++; $display("FAIL rnd%0d_desb a=%h b=%h got=%b want=%b", i, a, b, bus.Desborde, ed); end
      $display("rnd%0d: a=%h b=%h multip=%h res=%h desb=%b", i, a, b, bus.Multip, bus.Resultado, bus.Desborde);
    end
  endtask

  task automatic test_ignore_mid();
    logic [23:0] a, b, er;
    logic [47:0] em;
    logic ed;
    int lat;
    a = 24'($urandom);
    b = 24'($urandom_range(1, 65535));
    model(a, b, em, er, ed);
    bus.iniciar = 1'b1;
    bus.Multiplicandos = a;
    bus.Constantes = b;
    @(posedge clk); #1;
    bus.iniciar = 1'b0;
    lat = 0;
    while (bus.listo !== 1'b1 && lat < 200) begin
      if (lat == 4) begin
        bus.iniciar = 1'b1;
        bus.Multiplicandos = ~a;
        bus.Constantes = b + 24'd77;
      end
      if (lat == 7) bus.iniciar = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    total += 4;
    if (lat !== LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, LAT); end
    if (bus.Multip !== em) begin bad++; $display("FAIL ignore_multip got=%h want=%h", bus.Multip, em); end
    if (bus.Resultado !== er) begin bad++; $display("FAIL ignore_res got=%h want=%h", bus.Resultado, er); end
    @(posedge clk); #1;
    if (bus.ocupado !== 1'b0) begin bad++; $display("FAIL ignore_no_queue got=%b want=0", bus.ocupado); end
    $display("ignore: a=%h b=%h multip=%h res=%h", a, b, bus.Multip, bus.Resultado);
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.iniciar = 1'b1;
    bus.Multiplicandos = 24'h123456;
    bus.Constantes = 24'h000345;
    @(posedge clk); #1;
    bus.iniciar = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total += 5;
    if (bus.ocupado !== 1'b0) begin bad++; $display("FAIL rstmid_ocupado got=%b want=0", bus.ocupado); end
    if (bus.listo !== 1'b0) begin bad++; $display("FAIL rstmid_listo got=%b want=0", bus.listo); end
    if (bus.Multip !== 48'h0) begin bad++; $display("FAIL rstmid_multip got=%h want=0", bus.Multip); end
    if (bus.Resultado !== 24'h0) begin bad++; $display("FAIL rstmid_res got=%h want=0", bus.Resultado); end
    if (bus.Desborde !== 1'b0) begin bad++; $display("FAIL rstmid_desb got=%b want=0", bus.Desborde); end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.listo === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_listo got=%b want=0", seen); end
    $display("reset_mid: ocupado=%b multip=%h listo_seen=%b", bus.ocupado, bus.Multip, seen);
  endtask

  task automatic test_back_to_back();
    logic [23:0] a2, b2, er;
    logic [47:0] em;
    logic ed;
    int lat, ocnt, gap;
    a2 = 24'($urandom);
    b2 = 24'($urandom);
    model(a2, b2, em, er, ed);
    run_op(24'h000400, 24'h000100, lat, ocnt);
    total++;
    if (bus.Resultado !== 24'h000400) begin bad++; $display("FAIL b2b_first_res got=%h want=000400", bus.Resultado); end
    bus.iniciar = 1'b1;
    bus.Multiplicandos = a2;
    bus.Constantes = b2;
    @(posedge clk); #1;
    bus.iniciar = 1'b0;
    gap = 1;
    while (bus.listo !== 1'b1 && gap < 200) begin
      @(posedge clk); #1;
      gap++;
    end
    total += 4;
    if (gap !== LAT + 1) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", gap, LAT + 1); end
    if (bus.Multip !== em) begin bad++; $display("FAIL b2b_multip got=%h want=%h", bus.Multip, em); end
    if (bus.Resultado !== er) begin bad++; $display("FAIL b2b_res got=%h want=%h", bus.Resultado, er); end
    if (bus.Desborde !== ed) begin bad++; $display("FAIL b2b_desb got=%b want=%b", bus.Desborde, ed); end
    $display("b2b: gap=%0d a=%h b=%h multip=%h res=%h", gap, a2, b2, bus.Multip, bus.Resultado);
  endtask

  initial begin
    bus.iniciar = 1'b0;
    bus.Multiplicandos = '0;
    bus.Constantes = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_random();
    test_ignore_mid();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
